// File: rtl/timer_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : timer_scheduler_pkg
// Purpose : Shared definitions for the timer scheduler: FSM state encoding
//           and default sizing constants.
// Ports   : (package, no ports)
// Config  : none
// Rev     : 1.0  initial release
// ============================================================================
package timer_scheduler_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/timer_scheduler_tick_counter.sv
`default_nettype none
// ============================================================================
// Module  : tick_counter
// Purpose : Shared up-counter with a latched terminal value.
// Ports   : clk, rst_n      - clock, async active-low reset
//           load_i          - latch n_i as period and restart count at 0
//           n_i [WIDTH]     - period to latch on load_i
//           en_i            - advance the count (stops at terminal)
//           clr_i           - return count to 0
//           count_o [WIDTH] - current count
//           tc_o            - count has reached terminal (n-1)
// Config  : none
// Rev     : 1.0  initial release
// ============================================================================
module tick_counter
  import timer_scheduler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] n_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] term_q;

  // Periods of 0 and 1 both terminate at count 0, giving one running cycle.
  // Because the terminal is at most 2^WIDTH-1 the count can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      term_q  <= '0;
    end else if (load_i) begin
      count_q <= '0;
      term_q  <= (n_i == '0) ? '0 : n_i - 1'b1;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != term_q)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == term_q);

endmodule
`default_nettype wire

// File: rtl/timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : timer_scheduler
// Purpose : Grants a shared timer to one of NUM_REQ requesters at a time.
//           The grantee's period is latched at grant; the timer runs n
//           cycles, then a one-cycle done pulse is returned to the grantee.
// Ports   : clk, rst_n             - clock, async active-low reset
//           req_i   [NUM_REQ]      - level requests
//           n_i     [NUM_REQ*WIDTH]- packed periods, slice k = [k*WIDTH +: WIDTH]
//           gnt_q   [NUM_REQ]      - one-hot registered grant
//           owner_q [clog2]        - index of current or last grantee
//           busy_q                 - grant active
//           curr_time_q [WIDTH]    - shared timer count
//           done_q  [NUM_REQ]      - one-cycle completion pulse
// Config  : TIMER_SCHED_FIXED_PRIO_EN - fixed priority (lowest index wins)
//           instead of round-robin.
// Rev     : 1.0  initial release
// ============================================================================
module timer_scheduler
  import timer_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  localparam int OW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] n_i,
  output logic [NUM_REQ-1:0]       gnt_q,
  output logic [OW-1:0]            owner_q,
  output logic                     busy_q,
  output logic [WIDTH-1:0]         curr_time_q,
  output logic [NUM_REQ-1:0]       done_q
);

  localparam logic [OW-1:0] C_OWNER_RST = OW'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_d, done_d;
  logic [OW-1:0]        owner_d;
  logic                 busy_d;

  logic                 win_valid;
  logic [OW-1:0]        win_idx;
  int                   arb_idx;

  logic                 cnt_load, cnt_en, cnt_clr, cnt_tc;
  logic [WIDTH-1:0]     n_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_nslice
    assign n_arr[k] = n_i[k*WIDTH +: WIDTH];
  end

  // Scan candidates from lowest to highest priority so the last hit (the
  // highest priority requester) is the one that sticks.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    arb_idx   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
`ifdef TIMER_SCHED_FIXED_PRIO_EN
      arb_idx = i;
`else
      arb_idx = (int'(owner_q) + 1 + i) % NUM_REQ;
`endif
      if (req_i[arb_idx[OW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = arb_idx[OW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    done_d   = '0;
    busy_d   = 1'b0;
    owner_d  = owner_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d          = RUN;
          gnt_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
          busy_d           = 1'b1;
          cnt_load         = 1'b1;
        end
      end
      RUN: begin
        if (!req_i[owner_q]) begin
          // Grantee abandoned its request: silent abort, no done pulse.
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d         = DONE;
          done_d[owner_q] = 1'b1;
          cnt_clr         = 1'b1;
        end else begin
          gnt_d  = gnt_q;
          busy_d = 1'b1;
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      owner_q <= C_OWNER_RST;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  tick_counter #(
    .WIDTH (WIDTH)
  ) u_tick_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (cnt_load),
    .n_i     (n_arr[win_idx]),
    .en_i    (cnt_en),
    .clr_i   (cnt_clr),
    .count_o (curr_time_q),
    .tc_o    (cnt_tc)
  );

endmodule
`default_nettype wire
